// File: rtl/puf_response_collector_pkg.sv
// Shared definitions for the PUF response collector.
//   state_t        : controller state encoding
//   LFSR_TAPS      : feedback tap mask of the challenge LFSR (bits 7,5,4,3)
//   ZERO_SEED_SUB  : value loaded instead of an all-zero seed (zero is a lock-up state)
package puf_response_collector_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_DECIDE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [7:0] LFSR_TAPS     = 8'hB8;
    localparam logic [7:0] ZERO_SEED_SUB = 8'h01;

endpackage

// File: rtl/puf_response_collector_lfsr8_step.sv
// One step of the 8-bit challenge LFSR (purely combinational).
//   cur : current LFSR value
//   nxt : next value, shifted left with the tap parity in bit 0
module lfsr8_step
    import puf_response_collector_pkg::*;
(
    input  logic [7:0] cur,
    output logic [7:0] nxt
);

    assign nxt = {cur[6:0], ^(cur & LFSR_TAPS)};

endmodule

// File: rtl/puf_response_collector.sv
// Arbiter-PUF response collector: drives LFSR challenges, majority-votes
// VOTES samples of the arbiter bit per challenge and packs NBITS voted bits
// (first challenge in the MSB) into resp, with a start/done/ack handshake.
//   clk, rst : clock, asynchronous active-high reset
//   start    : request a measurement (IDLE only); seed latched with it
//   ack      : CPU has consumed resp (DONE only; wins over start)
//   arb_out  : arbiter response bit, sampled only in SAMPLE
//   chal     : challenge driven to the arbiter
//   busy     : measurement in progress
//   done     : resp valid and stable
//   resp     : collected response word
// busy and done are registered decodes of the state, so they trail the
// state register by one cycle; done therefore rises one edge after the
// final DECIDE.
module puf_response_collector
    import puf_response_collector_pkg::*;
#(
    parameter int unsigned NBITS  = 32,
    parameter int unsigned SETTLE = 4,
    parameter int unsigned VOTES  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       seed,
    input  logic             ack,
    input  logic             arb_out,
    output logic [7:0]       chal,
    output logic             busy,
    output logic             done,
    output logic [NBITS-1:0] resp
);

    localparam int unsigned CW = 4;  // ones / votes counters
    localparam int unsigned BW = 5;  // bit counter
    localparam int unsigned SW = 8;  // settle counter

    state_t         state;
    state_t         next_state;
    logic [CW-1:0]  ones;
    logic [CW-1:0]  votes;
    logic [CW-1:0]  votes_inc;
    logic [BW-1:0]  bit_cnt;
    logic [SW-1:0]  settle_cnt;
    logic [7:0]     lfsr_next;
    logic           settle_last;
    logic           vote_bit;

    lfsr8_step u_lfsr (
        .cur (chal),
        .nxt (lfsr_next)
    );

    assign votes_inc   = votes + CW'(1);
    assign settle_last = (settle_cnt == SW'(SETTLE - 1));
    assign vote_bit    = (ones > CW'(VOTES / 2));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (start) next_state = ST_APPLY;
            ST_APPLY:  if (settle_last) next_state = ST_SAMPLE;
            ST_SAMPLE: next_state = (votes_inc < CW'(VOTES)) ? ST_APPLY : ST_DECIDE;
            ST_DECIDE: next_state = (bit_cnt == BW'(NBITS - 1)) ? ST_DONE : ST_APPLY;
            ST_DONE:   if (ack) next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Datapath: counters, challenge, response and status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chal       <= 8'h00;
            resp       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ones       <= '0;
            votes      <= '0;
            bit_cnt    <= '0;
            settle_cnt <= '0;
        end else begin
            busy <= (state == ST_APPLY) || (state == ST_SAMPLE) || (state == ST_DECIDE);
            done <= (state == ST_DONE);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        chal       <= (seed == 8'h00) ? ZERO_SEED_SUB : seed;
                        resp       <= '0;
                        ones       <= '0;
                        votes      <= '0;
                        bit_cnt    <= '0;
                        settle_cnt <= '0;
                    end
                end
                ST_APPLY: begin
                    settle_cnt <= settle_last ? '0 : settle_cnt + SW'(1);
                end
                ST_SAMPLE: begin
                    ones       <= ones + {{(CW-1){1'b0}}, arb_out};
                    votes      <= votes_inc;
                    settle_cnt <= '0;
                end
                ST_DECIDE: begin
                    resp    <= {resp[NBITS-2:0], vote_bit};
                    ones    <= '0;
                    votes   <= '0;
                    chal    <= lfsr_next;
                    bit_cnt <= bit_cnt + BW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
